// File: rtl/cmd_defs.sv
// Shared definitions for the UART drive-command front end: command bytes,
// receiver state encoding and default timing parameters.
package cmd_defs;

    localparam int DEF_CLKS_PER_BIT   = 5208;
    localparam int DEF_TIMEOUT_CYCLES = 25_000_000;

    localparam logic [7:0] CMD_FWD_U   = 8'h57;
    localparam logic [7:0] CMD_FWD_L   = 8'h77;
    localparam logic [7:0] CMD_REV_U   = 8'h53;
    localparam logic [7:0] CMD_REV_L   = 8'h73;
    localparam logic [7:0] CMD_RIGHT_U = 8'h44;
    localparam logic [7:0] CMD_RIGHT_L = 8'h64;
    localparam logic [7:0] CMD_LEFT_U  = 8'h41;
    localparam logic [7:0] CMD_LEFT_L  = 8'h61;
    localparam logic [7:0] CMD_STOP_U  = 8'h58;
    localparam logic [7:0] CMD_STOP_L  = 8'h78;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling FSM.
// data_valid / frame_err are asserted on the STOP sample cycle.
module uart_rx_byte
    import cmd_defs::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta, rx_s, rx_prev;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg, shreg_nxt;

    // Synchroniser resets to idle-high so release never fakes a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        bit_nxt    = bit_idx;
        shreg_nxt  = shreg;
        data_valid = 1'b0;
        frame_err  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                bit_nxt = '0;
                if (rx_prev && !rx_s) state_nxt = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt    = '0;
                    state_nxt  = RX_IDLE;
                    data_valid = rx_s;
                    frame_err  = !rx_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign data = shreg;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Drive-command decoder: maps received bytes to one-hot direction levels
// and forces a stop when the link has been silent for TIMEOUT_CYCLES.
module uart_cmd_decoder
    import cmd_defs::*;
#(
    parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic frente,
    output logic tras,
    output logic direita,
    output logic esquerda,
    output logic cmd_valid,
    output logic cmd_err,
    output logic frame_err,
    output logic timeout
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;
    logic          hit;
    logic [3:0]    dir, dir_nxt;
    logic [WW-1:0] wdog;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (rx_data),
        .data_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    // dir bit order: {frente, tras, direita, esquerda}
    always_comb begin
        hit     = 1'b0;
        dir_nxt = '0;
        case (rx_data)
            CMD_FWD_U,   CMD_FWD_L:   begin hit = 1'b1; dir_nxt = 4'b1000; end
            CMD_REV_U,   CMD_REV_L:   begin hit = 1'b1; dir_nxt = 4'b0100; end
            CMD_RIGHT_U, CMD_RIGHT_L: begin hit = 1'b1; dir_nxt = 4'b0010; end
            CMD_LEFT_U,  CMD_LEFT_L:  begin hit = 1'b1; dir_nxt = 4'b0001; end
            CMD_STOP_U,  CMD_STOP_L:  begin hit = 1'b1; dir_nxt = 4'b0000; end
            default: ;
        endcase
    end

    // Expiry fires while the saturated counter still sees a live direction;
    // clearing the directions is what makes the pulse single-shot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir       <= '0;
            wdog      <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            timeout   <= 1'b0;
            frame_err <= rx_ferr;
            if (rx_valid && hit) begin
                dir       <= dir_nxt;
                wdog      <= '0;
                cmd_valid <= 1'b1;
            end else begin
                cmd_err <= rx_valid;
                if (wdog != WD_MAX) begin
                    wdog <= wdog + 1'b1;
                end else if (|dir) begin
                    dir     <= '0;
                    timeout <= 1'b1;
                end
            end
        end
    end

    assign frente   = dir[3];
    assign tras     = dir[2];
    assign direita  = dir[1];
    assign esquerda = dir[0];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder (CLKS_PER_BIT=8, TIMEOUT_CYCLES=1000).
module tb_uart_cmd_decoder;

    localparam int CPB = 8;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic frente, tras, direita, esquerda;
    logic cmd_valid, cmd_err, frame_err, timeout;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_ferr = 0, n_tmo = 0;
    int t_valid = 0, t_tmo = 0;

    uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .frente    (frente),
        .tras      (tras),
        .direita   (direita),
        .esquerda  (esquerda),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles, so a wide pulse shows up as extra counts.
    always @(negedge clk) begin
        cyc++;
        if (cmd_valid) begin n_valid++; t_valid = cyc; end
        if (cmd_err)   n_err++;
        if (frame_err) n_ferr++;
        if (timeout)   begin n_tmo++; t_tmo = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] dirs();
        return {frente, tras, direita, esquerda};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tmo(input string tag);
        int n0;
        n0 = n_tmo;
        for (int i = 0; i < 1500 && n_tmo == n0; i++) @(negedge clk);
        chk({tag, "_seen"}, 32'(n_tmo - n0), 32'd1);
        chk({tag, "_delay"}, 32'(t_tmo - t_valid), 32'(TMO));
    endtask

    initial begin
        int v0, e0, f0, t0;

        reset = 1'b1;
        idle(3);
        chk("rst_dirs", 32'(dirs()), 32'h0);
        chk("rst_pulses", 32'({cmd_valid, cmd_err, frame_err, timeout}), 32'h0);
        reset = 1'b0;
        idle(5);

        // Back-to-back W then a
        v0 = n_valid;
        send_byte(8'h57, 1'b1);
        chk("w_dirs", 32'(dirs()), 32'h8);
        chk("w_valid", 32'(n_valid - v0), 32'd1);
        send_byte(8'h61, 1'b1);
        chk("a_dirs", 32'(dirs()), 32'h1);
        chk("a_valid", 32'(n_valid - v0), 32'd2);
        idle(5);

        // Watchdog after lowercase w
        send_byte(8'h77, 1'b1);
        idle(3);
        chk("w2_dirs", 32'(dirs()), 32'h8);
        wait_tmo("tmo1");
        idle(2);
        chk("tmo1_dirs", 32'(dirs()), 32'h0);
        t0 = n_tmo;
        idle(3000);
        chk("tmo1_once", 32'(n_tmo - t0), 32'd0);

        // Unknown byte leaves direction and watchdog alone
        e0 = n_err;
        v0 = n_valid;
        send_byte(8'h44, 1'b1);
        chk("d_dirs", 32'(dirs()), 32'h2);
        send_byte(8'h5A, 1'b1);
        idle(3);
        chk("z_err", 32'(n_err - e0), 32'd1);
        chk("z_valid", 32'(n_valid - v0), 32'd1);
        chk("z_dirs", 32'(dirs()), 32'h2);
        wait_tmo("tmo2");
        idle(2);
        chk("tmo2_dirs", 32'(dirs()), 32'h0);

        // Framing error, then a good S
        f0 = n_ferr;
        v0 = n_valid;
        send_byte(8'h53, 1'b0);
        idle(4);
        chk("fe_count", 32'(n_ferr - f0), 32'd1);
        chk("fe_valid", 32'(n_valid - v0), 32'd0);
        chk("fe_dirs", 32'(dirs()), 32'h0);
        send_byte(8'h53, 1'b1);
        idle(3);
        chk("s_dirs", 32'(dirs()), 32'h4);

        // 3-cycle glitch, then X
        v0 = n_valid; e0 = n_err; f0 = n_ferr;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        chk("gl_pulses", 32'((n_valid - v0) + (n_err - e0) + (n_ferr - f0)), 32'd0);
        chk("gl_dirs", 32'(dirs()), 32'h4);
        send_byte(8'h58, 1'b1);
        idle(3);
        chk("x_valid", 32'(n_valid - v0), 32'd1);
        chk("x_dirs", 32'(dirs()), 32'h0);

        // Reset during DATA bits of 0x57
        send_byte(8'h57, 1'b1);
        idle(3);
        chk("pre_rst_dirs", 32'(dirs()), 32'h8);
        v0 = n_valid; e0 = n_err; f0 = n_ferr; t0 = n_tmo;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            idle(CPB);
        end
        rx = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        chk("mid_rst_dirs", 32'(dirs()), 32'h0);
        reset = 1'b0;
        idle(40);
        chk("post_rst_dirs", 32'(dirs()), 32'h0);
        chk("post_rst_pulses",
            32'((n_valid - v0) + (n_err - e0) + (n_ferr - f0) + (n_tmo - t0)), 32'd0);
        send_byte(8'h57, 1'b1);
        idle(3);
        chk("rst_w_dirs", 32'(dirs()), 32'h8);
        chk("rst_w_valid", 32'(n_valid - v0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
